// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies
// and op-class helpers.
package mdu_unit_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       mdu_op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output start, mdu_op, A, B,
        input  busy, hi, lo, rd_data
    );

    modport slave (
        input  start, mdu_op, A, B,
        output busy, hi, lo, rd_data
    );
endinterface

// File: rtl/mdu_unit_core.sv
// Combinational multiply/divide datapath returning {hi, lo}, including the
// divide-by-zero and signed-overflow result rules.
module mdu_core
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    always_comb begin
        result = '0;
        q      = '0;
        r      = '0;
        case (op)
            OP_MULT: begin
                result = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
            end
            OP_MULTU: begin
                result = {ZERO, a} * {ZERO, b};
            end
            OP_DIV: begin
                if (b == ZERO) begin
                    result = {a, ONES};
                end else if (a == MOST_NEG && b == ONES) begin
                    result = {ZERO, a};
                end else begin
                    // SV signed divide truncates toward zero; remainder follows the dividend
                    q      = $signed(a) / $signed(b);
                    r      = $signed(a) % $signed(b);
                    result = {r, q};
                end
            end
            OP_DIVU: begin
                if (b == ZERO) begin
                    result = {a, ONES};
                end else begin
                    q      = a / b;
                    r      = a % b;
                    result = {r, q};
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: accepts md ops into shadow
// registers, counts down the latency, then commits; also handles mthi/mtlo/mfhi/mflo.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    mdu_unit_if.slave bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   shadow_hi;
    logic [WIDTH-1:0]   shadow_lo;
    logic               busy_q;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] core_result;
    logic [WIDTH-1:0]   rd_mux;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .op     (bus.mdu_op),
        .a      (bus.A),
        .b      (bus.B),
        .result (core_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            busy_q    <= 1'b0;
            count     <= '0;
        end else if (busy_q) begin
            // issue strobes are ignored while in flight; the hazard unit stalls them
            if (count == '0) begin
                hi_q   <= shadow_hi;
                lo_q   <= shadow_lo;
                busy_q <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end else if (bus.start) begin
            if (is_md_op(bus.mdu_op)) begin
                shadow_hi <= core_result[2*WIDTH-1:WIDTH];
                shadow_lo <= core_result[WIDTH-1:0];
                count     <= is_div_op(bus.mdu_op) ? DIV_LOAD : MUL_LOAD;
                busy_q    <= 1'b1;
            end else if (bus.mdu_op == OP_MTHI) begin
                hi_q <= bus.A;
            end else if (bus.mdu_op == OP_MTLO) begin
                lo_q <= bus.A;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (bus.mdu_op == OP_MFHI) begin
            rd_mux = hi_q;
        end else if (bus.mdu_op == OP_MFLO) begin
            rd_mux = lo_q;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rd_data = rd_mux;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with hand-computed HI/LO results.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    mdu_unit_if #(.WIDTH(W)) bus ();

    mdu_unit #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // caller sits at a negedge; strobe is sampled at the following posedge
    task automatic pulse(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.A      = a;
        bus.B      = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = OP_NOP;
        bus.A      = '0;
        bus.B      = '0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 50) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 50) begin
            checks++;
            failures++;
            $display("FAIL wait_done timeout: busy still %b after %0d cycles", bus.busy, cycles);
        end
    endtask

    task automatic run_md(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cyc;
        pulse(op, a, b);
        wait_done(cyc);
        checks++;
        if (cyc !== lat) begin
            failures++;
            $display("FAIL %s_latency: busy cycles %0d, expected %0d", name, cyc, lat);
        end
        checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            failures++;
            $display("FAIL %s_result: hi=%h lo=%h, expected hi=%h lo=%h",
                     name, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.mdu_op = OP_NOP;
        bus.A      = '0;
        bus.B      = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b, expected 0/0/0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_reset_midop();
        pulse(OP_MULT, 32'd3, 32'd4);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midop_busy: busy=%b, expected 1", bus.busy);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: hi=%h lo=%h busy=%b, expected 0/0/0", bus.hi, bus.lo, bus.busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midop_no_commit: hi=%h lo=%h busy=%b, expected 0/0/0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_mult();
        run_md("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        run_md("div",       OP_DIV,  32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_zero", OP_DIVU, 32'd7,         32'd0,        10, 32'd7,         32'hFFFF_FFFF);
        run_md("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,        32'h8000_0000);
        run_md("div_zero",  OP_DIV,  32'hFFFF_FFF0, 32'd0,        10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    endtask

    task automatic test_busy_moves();
        int cyc;
        pulse(OP_DIVU, 32'd100, 32'd7);
        pulse(OP_MTHI, 32'h1234, 32'd0);
        wait_done(cyc);
        checks++;
        if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            failures++;
            $display("FAIL mthi_ignored: hi=%h lo=%h, expected hi=%h lo=%h", bus.hi, bus.lo, 32'd2, 32'd14);
        end
        pulse(OP_MTLO, 32'hABCD, 32'd0);
        checks++;
        if (bus.lo !== 32'hABCD || bus.busy !== 1'b0 || bus.hi !== 32'd2) begin
            failures++;
            $display("FAIL mtlo: lo=%h hi=%h busy=%b, expected lo=0000abcd hi=00000002 busy=0",
                     bus.lo, bus.hi, bus.busy);
        end
        bus.mdu_op = OP_MFLO;
        #1;
        checks++;
        if (bus.rd_data !== 32'hABCD) begin
            failures++;
            $display("FAIL rd_mflo: rd_data=%h, expected 0000abcd", bus.rd_data);
        end
        bus.mdu_op = OP_MFHI;
        #1;
        checks++;
        if (bus.rd_data !== 32'd2) begin
            failures++;
            $display("FAIL rd_mfhi: rd_data=%h, expected 00000002", bus.rd_data);
        end
        bus.mdu_op = OP_NOP;
        #1;
        checks++;
        if (bus.rd_data !== 32'h0) begin
            failures++;
            $display("FAIL rd_nop: rd_data=%h, expected 00000000", bus.rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_md("b2b_first",  OP_MULTU, 32'h0001_0000, 32'h0001_0000, 5, 32'h1, 32'h0);
        run_md("b2b_second", OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0, 32'h1);
        run_md("b2b_third",  OP_DIVU,  32'd9,         32'd4,         10, 32'd1, 32'd2);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_reset_midop();
        test_mult();
        test_div();
        test_busy_moves();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in EX beside the ALU. It owns the HI/LO architectural registers and executes mult/multu/div/divu with a programmable latency. It also executes mthi/mtlo and exposes HI/LO for mfhi/mflo. A busy flag lets the hazard unit stall md-class instructions.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >=8)
MUL_LAT, 5, cycles from accepted multiply to HI/LO commit (>=1)
DIV_LAT, 10, cycles from accepted divide to HI/LO commit (>=1)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  issue strobe, one cycle, qualified by mdu_op
mdu_op  in  4  operation code (see Decomposition)
A  in  WIDTH  rs operand
B  in  WIDTH  rt operand
busy  out  1  an operation is in flight
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO
rd_data  out  WIDTH  combinational: hi if mdu_op==MFHI, lo if MFLO, else 0

Behaviour:
- Reset (reset_n low, async): hi=0, lo=0, busy=0, counter=0, shadow regs=0. Asserting reset mid-operation aborts it; HI/LO are not updated.
- Acceptance: start=1 and busy=0 at a rising edge.
  - MULT/MULTU/DIV/DIVU: capture op, A, B; compute the result into the shadow registers; load counter with LAT-1; busy=1 from the next cycle.
  - MTHI/MTLO: hi<=A or lo<=A at that edge; busy stays 0.
  - MFHI/MFLO/NOP: no state change.
- start while busy=1: ignored, with no state change. The hazard unit must stall instead.
- Countdown: while busy, counter decrements each cycle. At the edge where counter==0, hi/lo<=shadow and busy<=0.
  - Result is visible on hi/lo the cycle busy falls.
  - busy is high exactly MUL_LAT or DIV_LAT cycles.
- Back-to-back: a new start is accepted in the first cycle busy=0. No same-cycle overlap with completion.
- MULT: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits. MULTU: same, unsigned.
- DIV: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B==0): lo = all ones, hi = A. Applies to both signed and unsigned; latency unchanged.
- Signed overflow (A = most negative value, B = -1): lo = A, hi = 0.
- hi and lo are registered outputs and never glitch. rd_data is purely combinational.
- No flush input. Exception cancel is handled upstream by not issuing start.

Decomposition:
- Shared package/header mdu_defs holds the op codes:
  - NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Other codes behave as NOP.
  - It also holds the default latency constants.
- One natural sub-module: mdu_core, a combinational signed/unsigned multiply/divide returning {hi,lo} with the zero-divisor and overflow rules.
- Sequencing, counter and HI/LO stay in mdu_unit.

Test Plan:
- Reset mid-op: MULT A=3 B=4, pulse reset_n low at cycle 2 -> hi=0, lo=0, busy=0 after reset; no later commit.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy/move interaction:
  - MTHI A=0x1234 while busy -> ignored.
  - After completion, MTLO A=0xABCD -> lo=0xABCD next cycle, busy stays 0.
  - With mdu_op=MFLO, rd_data=0xABCD combinationally.
  - A start issued the first cycle busy=0 is accepted.
